// File: rtl/kcore_fifo_stream_drain.sv
// kcore_fifo_stream_drain: pops len words from an ap_fifo-style source
// and re-presents them on a valid/ready stream via a 2-entry buffer.
module kcore_fifo_stream_drain #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read,
  output logic                  fifo_read_ce,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [LEN_WIDTH-1:0]  words_read
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  words_cnt;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  hd;
  logic                  tl;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;
  logic                  rem_one;

  assign rem_one      = (remaining == LEN_WIDTH'(1));
  assign tl           = hd ^ count[0];
  assign push         = fifo_read;
  assign pop          = (count != 2'd0) & m_ready;
  assign m_valid      = (count != 2'd0);
  assign m_data       = buf_data[hd];
  assign m_last       = buf_last[hd] & m_valid;
  assign words_read   = words_cnt;
  assign fifo_read_ce = 1'b1;

  // Next state plus the handshake outputs that depend on it.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    fifo_read = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy      = 1'b1;
        fifo_read = fifo_empty_n & (remaining != '0)
                  & (count < 2'd2) & ~reset;
        if (fifo_read && rem_one) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (count == 2'd0 || (count == 2'd1 && m_ready)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Transfer length bookkeeping, loaded on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      words_cnt <= '0;
    end else if (state == IDLE && start) begin
      remaining <= len;
      words_cnt <= '0;
    end else if (push) begin
      remaining <= remaining - LEN_WIDTH'(1);
      words_cnt <= words_cnt + LEN_WIDTH'(1);
    end
  end

  // Two-entry output buffer: tail write on pop from source, head advance on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      hd          <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        buf_data[tl] <= fifo_dout;
        buf_last[tl] <= rem_one;
      end
      if (pop) begin
        hd <= ~hd;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_kcore_fifo_stream_drain.sv
// Bench for kcore_fifo_stream_drain: FIFO source model, scoreboard
// queue of expected stream words, negedge monitor comparing accepts.
module tb_kcore_fifo_stream_drain;

  localparam int DW = 64;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          fifo_empty_n;
  logic [DW-1:0] fifo_dout;
  logic          fifo_read;
  logic          fifo_read_ce;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [LW-1:0] words_read;

  kcore_fifo_stream_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .fifo_empty_n (fifo_empty_n),
    .fifo_dout    (fifo_dout),
    .fifo_read    (fifo_read),
    .fifo_read_ce (fifo_read_ce),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .words_read   (words_read)
  );

  always #5 clk = ~clk;

  // source FIFO model
  logic [DW-1:0] fifo_mem [64];
  int            fifo_cnt = 0;
  int            rd_idx = 0;
  logic          gate;
  logic          fifo_flush;

  assign fifo_empty_n = gate && (rd_idx != fifo_cnt);
  assign fifo_dout    = fifo_mem[rd_idx[5:0]];

  always @(posedge clk) begin
    if (fifo_flush) rd_idx <= fifo_cnt;
    else if (fifo_read && fifo_empty_n) rd_idx <= rd_idx + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard and monitor
  logic [DW:0]   exp_q [$];
  int            pops, done_cnt, valid_cnt;
  int            first_pop, last_pop, first_acc, last_acc;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (fifo_read && fifo_empty_n) begin
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end
    if (done) done_cnt++;
    if (m_valid) valid_cnt++;
    if (m_valid && prev_stall)
      check("stall_stable", m_data, prev_data);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", m_data, '1);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("m_data", m_data, e[DW-1:0]);
        check("m_last", 64'(m_last), 64'(e[DW]));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pops = 0; done_cnt = 0; valid_cnt = 0;
    first_pop = -1; last_pop = -1;
    first_acc = -1; last_acc = -1;
  endtask

  task automatic load(input logic [DW-1:0] d);
    fifo_mem[fifo_cnt[5:0]] = d;
    fifo_cnt++;
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic flush_src();
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
  endtask

  task automatic go(input logic [LW-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    tick();
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0;
    m_ready = 1'b0; gate = 1'b1; fifo_flush = 1'b0;
    clr();
    repeat (3) tick();
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_fifo_read", 64'(fifo_read), 0);
    check("rst_m_valid", 64'(m_valid), 0);
    check("rst_m_last", 64'(m_last), 0);
    check("rst_m_data", m_data, 0);
    check("rst_words_read", 64'(words_read), 0);
    reset = 1'b0;
    tick();

    // len=4, streaming at full rate, one spare word stays in the FIFO
    for (int i = 0; i < 5; i++) load(64'hA0 + 64'(i));
    for (int i = 0; i < 4; i++) expect_word(64'hA0 + 64'(i), i == 3);
    m_ready = 1'b1;
    clr();
    go(4);
    wait_done(50);
    check("t1_pops", 64'(pops), 4);
    check("t1_pop_span", 64'(last_pop - first_pop), 3);
    check("t1_acc_span", 64'(last_acc - first_acc), 3);
    check("t1_words_read", 64'(words_read), 4);
    check("t1_fifo_left", 64'(fifo_cnt - rd_idx), 1);
    check("t1_done_cnt", 64'(done_cnt), 1);
    flush_src();

    // len=3 with downstream stalled for 10 cycles
    for (int i = 0; i < 4; i++) load(64'hB0 + 64'(i));
    for (int i = 0; i < 3; i++) expect_word(64'hB0 + 64'(i), i == 2);
    m_ready = 1'b0;
    clr();
    go(3);
    repeat (10) tick();
    check("t2_stall_pops", 64'(pops), 2);
    check("t2_stall_read", 64'(fifo_read), 0);
    check("t2_stall_valid", 64'(m_valid), 1);
    check("t2_stall_head", m_data, 64'hB0);
    m_ready = 1'b1;
    wait_done(50);
    check("t2_pops", 64'(pops), 3);
    check("t2_words_read", 64'(words_read), 3);
    flush_src();

    // len=5 with the source toggling empty every cycle
    for (int i = 0; i < 6; i++) load(64'hC0 + 64'(i));
    for (int i = 0; i < 5; i++) expect_word(64'hC0 + 64'(i), i == 4);
    clr();
    go(5);
    begin
      int n = 0;
      while (!done && n < 80) begin
        gate = ~gate;
        tick();
        n++;
      end
    end
    gate = 1'b1;
    check("t3_done_seen", 64'(done), 1);
    tick();
    check("t3_pops", 64'(pops), 5);
    check("t3_done_cnt", 64'(done_cnt), 1);
    flush_src();

    // len=0: straight to done, no reads, no output
    load(64'hEE);
    clr();
    go(0);
    check("t4_busy", 64'(busy), 1);
    check("t4_done", 64'(done), 1);
    tick();
    check("t4_done_off", 64'(done), 0);
    check("t4_busy_off", 64'(busy), 0);
    tick();
    check("t4_pops", 64'(pops), 0);
    check("t4_valid", 64'(valid_cnt), 0);
    flush_src();

    // start during RUN is ignored
    for (int i = 0; i < 4; i++) load(64'hD0 + 64'(i));
    for (int i = 0; i < 2; i++) expect_word(64'hD0 + 64'(i), i == 1);
    clr();
    go(2);
    go(7);
    wait_done(50);
    repeat (3) tick();
    check("t5_pops", 64'(pops), 2);
    check("t5_words_read", 64'(words_read), 2);
    check("t5_done_cnt", 64'(done_cnt), 1);
    flush_src();

    // reset mid-transfer after 2 of 6 words
    for (int i = 0; i < 6; i++) load(64'hF0 + 64'(i));
    m_ready = 1'b0;
    clr();
    go(6);
    begin
      int n = 0;
      while (pops < 2 && n < 20) begin
        tick();
        n++;
      end
    end
    check("t6_pre_pops", 64'(pops), 2);
    reset = 1'b1;
    #1;
    check("t6_rst_read", 64'(fifo_read), 0);
    tick();
    reset = 1'b0;
    #1;
    check("t6_valid", 64'(m_valid), 0);
    check("t6_busy", 64'(busy), 0);
    check("t6_words_read", 64'(words_read), 0);
    check("t6_read", 64'(fifo_read), 0);
    flush_src();
    load(64'h5A);
    expect_word(64'h5A, 1'b1);
    m_ready = 1'b1;
    clr();
    go(1);
    wait_done(50);
    check("t6_new_pops", 64'(pops), 1);
    check("t6_new_words", 64'(words_read), 1);

    check("sb_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
